phase_timer_scheduler: RTL and testbench
========================================

Name: phase_timer_scheduler

Overview:
Timing and sequencing companion for the intersection light controller FSM. The controller announces each new phase. This block loads that phase's green/yellow duration and adjusts it from road density (L/H) and pedestrian requests. It counts the duration down in whole seconds and pulses phase_done so the FSM advances. This replaces the ad-hoc count_in/MaxTime compare with a single owned scheduler.

Parameters:
CLK_PER_SEC, 50000000, clock cycles per 1 s tick (benches override to 4)
T_MAIN_G, 20, main-road green seconds
T_LEFT, 10, main-road left-turn seconds
T_SIDE_G, 15, side-road green seconds
T_PED, 12, pedestrian phase seconds
T_YEL, 3, yellow seconds (both roads)
T_EXT, 5, density extension seconds
MAX_EXT, 2, max extensions per main-green phase
T_PED_CUT, 5, main-green remaining time after pedestrian truncation

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
phase  in  3  phase code: 0 INIT, 1 M, 2 M_L, 3 S, 4 PEDESTRIAN, 5 M_Y, 6 S_Y, 7 illegal
phase_load  in  1  1-cycle pulse: controller entered `phase`
L  in  3  light-traffic flags: bit0 main through, bit1 main left, bit2 side
H  in  3  heavy-traffic flags, same bit map
ped_btn  in  1  asynchronous pedestrian button, level
phase_done  out  1  1-cycle pulse: current phase expired
remaining  out  6  seconds left in current phase
busy  out  1  phase timing in progress
ped_pending  out  1  latched pedestrian request
sec_tick  out  1  1-cycle pulse each elapsed second while busy
err  out  1  sticky: illegal phase code loaded

Behaviour:
- Reset (reset_n=0, async): all outputs 0; prescaler, ext_cnt, btn sync and truncate flag cleared.
- ped_btn passes through a 2-flop synchronizer. A rising edge of the synchronized signal sets ped_pending.
- ped_pending clears on phase_load with phase=4. If set and clear occur in the same cycle, clear wins.
- Prescaler counts 0..CLK_PER_SEC-1 only while busy. sec_tick is asserted in the cycle it wraps. phase_load clears the prescaler, so the first second is full length.
- On phase_load, the duration D is computed and registered the next cycle:
  - phase 0: D=1.
  - phase 1: D=T_MAIN_G, plus T_EXT if H[0].
  - phase 2: D=T_LEFT if L[1]|H[1], else D=0 (left turn skipped).
  - phase 3: D=T_SIDE_G, plus T_EXT if H[2].
  - phase 4: D=T_PED.
  - phase 5 or 6: D=T_YEL.
  - phase 7: D=1 and err<=1.
  - All sums saturate at 63.
- Load result: remaining<=D; ext_cnt<=0; truncate flag<=0; busy<=(D!=0).
- If D=0: phase_done pulses in the cycle after the load; busy stays 0.
- On sec_tick with remaining>1: remaining decrements by 1.
- On sec_tick with remaining=1:
  - Extension case: phase=1, H[0]=1, ext_cnt<MAX_EXT and ped_pending=0. Then remaining<=T_EXT and ext_cnt increments; no phase_done.
  - Otherwise: remaining<=0, busy<=0, and phase_done=1 in the next cycle (registered, exactly one cycle).
- Pedestrian truncation: phase=1, busy, ped_pending=1, remaining>T_PED_CUT and truncate flag=0. Then remaining<=T_PED_CUT and the flag is set (once per phase). This takes priority over a same-cycle decrement.
- phase_load while busy aborts the running phase: reload with no phase_done for the aborted phase. phase_load coincident with sec_tick: the load wins.
- When not busy, remaining holds 0 and ticks are ignored until the next phase_load.
- err clears only on reset.

Test Plan:
1. CLK_PER_SEC=4; reset, then phase_load phase=5 → remaining=3 next cycle; sec_tick every 4 cycles; phase_done one cycle after remaining hits 0, 13 cycles after load; busy drops with remaining=0.
2. phase_load phase=1, H=3'b001 → remaining=25. Hold H[0]=1 → two reloads to 5 (ext_cnt=2), then phase_done; total 35 s.
3. phase_load phase=1, H=0; at remaining=15 pulse ped_btn → ped_pending=1 within 3 cycles, remaining=5, phase_done 5 s later. Then phase_load phase=4 → ped_pending=0, remaining=12.
4. phase_load phase=2 with L=H=0 → busy=0, phase_done pulse 1 cycle later. Repeat with L[1]=1 → remaining=10.
5. Abort and tie: phase_load phase=3 mid-count of phase 1 → remaining=15, no phase_done. phase_load coincident with a sec_tick → load wins, prescaler restarts.
6. phase=7 load → err=1, remaining=1. Assert reset_n=0 mid-count → all outputs 0 immediately (async).

Source files
------------

// File: rtl/phase_timer_scheduler.sv
// phase_timer_scheduler
//   Timing companion for the intersection light controller. Each time the
//   controller announces a phase (phase_load), this block works out how long
//   the phase lasts from the phase code, the road density flags and any
//   pedestrian request. It then counts that time down in whole seconds and
//   pulses phase_done so the controller can advance.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   phase[2:0]   phase code (0 INIT, 1 M, 2 M_L, 3 S, 4 PED, 5 M_Y, 6 S_Y, 7 illegal)
//   phase_load   1-cycle pulse, controller entered `phase`
//   L[2:0]       light-traffic flags (bit0 main through, bit1 main left, bit2 side)
//   H[2:0]       heavy-traffic flags, same bit map
//   ped_btn      asynchronous pedestrian button (level)
//   phase_done   1-cycle pulse, current phase expired
//   remaining    seconds left in the current phase
//   busy         phase timing in progress
//   ped_pending  latched pedestrian request
//   sec_tick     1-cycle pulse per elapsed second while busy
//   err          sticky flag, illegal phase code was loaded
module phase_timer_scheduler #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int T_MAIN_G    = 20,
  parameter int T_LEFT      = 10,
  parameter int T_SIDE_G    = 15,
  parameter int T_PED       = 12,
  parameter int T_YEL       = 3,
  parameter int T_EXT       = 5,
  parameter int MAX_EXT     = 2,
  parameter int T_PED_CUT   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] phase,
  input  logic       phase_load,
  input  logic [2:0] L,
  input  logic [2:0] H,
  input  logic       ped_btn,
  output logic       phase_done,
  output logic [5:0] remaining,
  output logic       busy,
  output logic       ped_pending,
  output logic       sec_tick,
  output logic       err
);

  typedef enum logic [2:0] {
    PH_INIT = 3'd0,
    PH_M    = 3'd1,
    PH_ML   = 3'd2,
    PH_S    = 3'd3,
    PH_PED  = 3'd4,
    PH_MY   = 3'd5,
    PH_SY   = 3'd6,
    PH_BAD  = 3'd7
  } phase_t;

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

  // Durations clamp to what the 6-bit remaining counter can show.
  function automatic logic [5:0] satAdd(input int a, input int b);
    int s;
    s = a + b;
    return (s > 63) ? 6'd63 : 6'(s);
  endfunction

  localparam logic [5:0] T_EXT_C     = satAdd(T_EXT, 0);
  localparam logic [5:0] T_PED_CUT_C = satAdd(T_PED_CUT, 0);
  localparam logic [7:0] MAX_EXT_C   = (MAX_EXT > 255) ? 8'd255 : 8'(MAX_EXT);

  logic          r_btnMeta;
  logic          r_btnSync;
  logic          r_btnPrev;
  logic          r_pedPending;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_remaining;
  logic          r_busy;
  logic [7:0]    r_extCnt;
  logic          r_trunc;
  phase_t        r_phase;
  logic          r_expire;
  logic          r_phaseDone;
  logic          r_err;

  phase_t        w_phaseIn;
  logic [5:0]    w_loadDur;
  logic          w_secTick;
  logic          w_pedRise;
  logic          w_pedClear;
  logic          w_extend;
  logic          w_truncate;
  logic          w_unused;

  // Only the main-left light flag feeds a decision; the other L bits are
  // part of the shared bus but unused here.
  assign w_unused = &{1'b0, L[0], L[2]};

  assign w_phaseIn  = phase_t'(phase);
  assign w_secTick  = r_busy && (r_presc == PRESC_MAX);
  assign w_pedRise  = r_btnSync && !r_btnPrev;
  assign w_pedClear = phase_load && (w_phaseIn == PH_PED);

  // A heavy main road earns another T_EXT seconds, unless a pedestrian is waiting.
  assign w_extend = (r_phase == PH_M) && H[0] && (r_extCnt < MAX_EXT_C) && !r_pedPending;

  // Pedestrian request cuts a long main green short, at most once per phase.
  assign w_truncate = (r_phase == PH_M) && r_busy && r_pedPending &&
                      (r_remaining > T_PED_CUT_C) && !r_trunc;

  // Duration for the phase being announced this cycle.
  always_comb begin
    w_loadDur = 6'd1;
    case (w_phaseIn)
      PH_INIT: w_loadDur = 6'd1;
      PH_M:    w_loadDur = satAdd(T_MAIN_G, H[0] ? T_EXT : 0);
      PH_ML:   w_loadDur = (L[1] || H[1]) ? satAdd(T_LEFT, 0) : 6'd0;
      PH_S:    w_loadDur = satAdd(T_SIDE_G, H[2] ? T_EXT : 0);
      PH_PED:  w_loadDur = satAdd(T_PED, 0);
      PH_MY,
      PH_SY:   w_loadDur = satAdd(T_YEL, 0);
      PH_BAD:  w_loadDur = 6'd1;
      default: w_loadDur = 6'd1;
    endcase
  end

  // Button synchronizer; the third flop gives the previous synchronized
  // level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btnMeta <= 1'b0;
      r_btnSync <= 1'b0;
      r_btnPrev <= 1'b0;
    end else begin
      r_btnMeta <= ped_btn;
      r_btnSync <= r_btnMeta;
      r_btnPrev <= r_btnSync;
    end
  end

  // Entering the pedestrian phase serves the request; clear beats set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pedPending <= 1'b0;
    end else if (w_pedClear) begin
      r_pedPending <= 1'b0;
    end else if (w_pedRise) begin
      r_pedPending <= 1'b1;
    end
  end

  // Phase timing. r_expire marks the cycle remaining reaches zero; phase_done
  // follows one cycle later. A new load always overrides the running phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= '0;
      r_remaining <= 6'd0;
      r_busy      <= 1'b0;
      r_extCnt    <= 8'd0;
      r_trunc     <= 1'b0;
      r_phase     <= PH_INIT;
      r_expire    <= 1'b0;
      r_phaseDone <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_expire    <= 1'b0;
      r_phaseDone <= r_expire;
      if (phase_load) begin
        r_phase     <= w_phaseIn;
        r_remaining <= w_loadDur;
        r_extCnt    <= 8'd0;
        r_trunc     <= 1'b0;
        r_busy      <= (w_loadDur != 6'd0);
        r_presc     <= '0;
        r_expire    <= (w_loadDur == 6'd0);
        if (w_phaseIn == PH_BAD) begin
          r_err <= 1'b1;
        end
      end else if (r_busy) begin
        if (w_secTick) begin
          r_presc <= '0;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
        if (w_truncate) begin
          r_remaining <= T_PED_CUT_C;
          r_trunc     <= 1'b1;
        end else if (w_secTick) begin
          if (r_remaining > 6'd1) begin
            r_remaining <= r_remaining - 6'd1;
          end else if (w_extend) begin
            r_remaining <= T_EXT_C;
            r_extCnt    <= r_extCnt + 8'd1;
          end else begin
            r_remaining <= 6'd0;
            r_busy      <= 1'b0;
            r_expire    <= 1'b1;
          end
        end
      end
    end
  end

  assign phase_done  = r_phaseDone;
  assign remaining   = r_remaining;
  assign busy        = r_busy;
  assign ped_pending = r_pedPending;
  assign sec_tick    = w_secTick;
  assign err         = r_err;

endmodule

// File: tb/tb_phase_timer_scheduler.sv
// tb_phase_timer_scheduler
//   Directed bench for phase_timer_scheduler with a 4-cycle second. Each
//   scenario task drives its own stimulus and compares outputs against
//   hand-derived values. Inputs change and outputs are sampled on the
//   falling clock edge.
module tb_phase_timer_scheduler;

  logic       clk;
  logic       reset_n;
  logic [2:0] phase;
  logic       phase_load;
  logic [2:0] L;
  logic [2:0] H;
  logic       ped_btn;
  logic       phase_done;
  logic [5:0] remaining;
  logic       busy;
  logic       ped_pending;
  logic       sec_tick;
  logic       err;

  int total;
  int bad;

  phase_timer_scheduler #(.CLK_PER_SEC(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .phase       (phase),
    .phase_load  (phase_load),
    .L           (L),
    .H           (H),
    .ped_btn     (ped_btn),
    .phase_done  (phase_done),
    .remaining   (remaining),
    .busy        (busy),
    .ped_pending (ped_pending),
    .sec_tick    (sec_tick),
    .err         (err)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a one-cycle phase_load; returns on the falling edge after the
  // loading rising edge.
  task automatic applyStimulus(input logic [2:0] p);
    phase      = p;
    phase_load = 1'b1;
    @(negedge clk);
    phase_load = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got %0d expected 0", phase_done); end
    total++; if (remaining !== 6'd0) begin bad++; $display("[TB] FAIL reset_remaining got %0d expected 0", remaining); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got %0d expected 0", busy); end
    total++; if (ped_pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_ped got %0d expected 0", ped_pending); end
    total++; if (sec_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick got %0d expected 0", sec_tick); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got %0d expected 0", err); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got %0d expected 0", busy); end
  endtask

  // Yellow: 3 s, ticks at cycles 3/7/11, zero at 12, done pulse at 13.
  task automatic test_yellow;
    logic [5:0] expRem;
    applyStimulus(3'd5);
    total++; if (remaining !== 6'd3) begin bad++; $display("[TB] FAIL yel_load_rem got %0d expected 3", remaining); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL yel_load_busy got %0d expected 1", busy); end
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      expRem = (n < 12) ? 6'(3 - n / 4) : 6'd0;
      total++; if (remaining !== expRem) begin bad++; $display("[TB] FAIL yel_rem cyc=%0d got %0d expected %0d", n, remaining, expRem); end
      total++; if (sec_tick !== (n == 3 || n == 7 || n == 11)) begin bad++; $display("[TB] FAIL yel_tick cyc=%0d got %0d expected %0d", n, sec_tick, (n == 3 || n == 7 || n == 11)); end
      total++; if (phase_done !== (n == 13)) begin bad++; $display("[TB] FAIL yel_done cyc=%0d got %0d expected %0d", n, phase_done, (n == 13)); end
      total++; if (busy !== (n < 12)) begin bad++; $display("[TB] FAIL yel_busy cyc=%0d got %0d expected %0d", n, busy, (n < 12)); end
    end
  endtask

  // Heavy main road: 25 s, then two 5 s extensions, 35 ticks total.
  task automatic test_extension;
    int t;
    logic [5:0] expRem;
    H = 3'b001;
    applyStimulus(3'd1);
    for (int n = 0; n <= 142; n++) begin
      if (n > 0) @(negedge clk);
      if (n % 4 == 0) begin
        t = n / 4;
        if (t < 25)      expRem = 6'(25 - t);
        else if (t < 30) expRem = 6'(30 - t);
        else if (t < 35) expRem = 6'(35 - t);
        else             expRem = 6'd0;
        total++; if (remaining !== expRem) begin bad++; $display("[TB] FAIL ext_rem sec=%0d got %0d expected %0d", t, remaining, expRem); end
      end
      total++; if (phase_done !== (n == 141)) begin bad++; $display("[TB] FAIL ext_done cyc=%0d got %0d expected %0d", n, phase_done, (n == 141)); end
    end
    H = 3'b000;
  endtask

  // Pedestrian press at remaining=15 truncates main green to 5 s.
  task automatic test_ped_truncate;
    applyStimulus(3'd1);
    for (int n = 0; n <= 46; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 20) begin
        total++; if (remaining !== 6'd15) begin bad++; $display("[TB] FAIL ped_rem15 got %0d expected 15", remaining); end
      end
      if (n == 22) begin
        total++; if (ped_pending !== 1'b0) begin bad++; $display("[TB] FAIL ped_early got %0d expected 0", ped_pending); end
      end
      if (n == 23) begin
        total++; if (ped_pending !== 1'b1) begin bad++; $display("[TB] FAIL ped_latch got %0d expected 1", ped_pending); end
        total++; if (remaining !== 6'd15) begin bad++; $display("[TB] FAIL ped_pre_cut got %0d expected 15", remaining); end
      end
      if (n == 24) begin
        total++; if (remaining !== 6'd5) begin bad++; $display("[TB] FAIL ped_cut got %0d expected 5", remaining); end
      end
      if (n == 40) begin
        total++; if (remaining !== 6'd1) begin bad++; $display("[TB] FAIL ped_rem1 got %0d expected 1", remaining); end
      end
      if (n == 44) begin
        total++; if (remaining !== 6'd0) begin bad++; $display("[TB] FAIL ped_rem0 got %0d expected 0", remaining); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ped_busy got %0d expected 0", busy); end
      end
      total++; if (phase_done !== (n == 45)) begin bad++; $display("[TB] FAIL ped_done cyc=%0d got %0d expected %0d", n, phase_done, (n == 45)); end
      ped_btn = (n == 20 || n == 21);
    end
    ped_btn = 1'b0;
    applyStimulus(3'd4);
    total++; if (ped_pending !== 1'b0) begin bad++; $display("[TB] FAIL ped_clear got %0d expected 0", ped_pending); end
    total++; if (remaining !== 6'd12) begin bad++; $display("[TB] FAIL ped_phase_rem got %0d expected 12", remaining); end
  endtask

  // Left turn skipped with no demand; then timed when L[1] is set.
  task automatic test_skip_left;
    L = 3'b000;
    H = 3'b000;
    applyStimulus(3'd2);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL skip_busy got %0d expected 0", busy); end
    total++; if (remaining !== 6'd0) begin bad++; $display("[TB] FAIL skip_rem got %0d expected 0", remaining); end
    total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL skip_done_early got %0d expected 0", phase_done); end
    @(negedge clk);
    total++; if (phase_done !== 1'b1) begin bad++; $display("[TB] FAIL skip_done got %0d expected 1", phase_done); end
    @(negedge clk);
    total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL skip_done_width got %0d expected 0", phase_done); end
    L = 3'b010;
    applyStimulus(3'd2);
    total++; if (remaining !== 6'd10) begin bad++; $display("[TB] FAIL left_rem got %0d expected 10", remaining); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL left_busy got %0d expected 1", busy); end
    L = 3'b000;
  endtask

  // Abort a running main green with a side load; then load on a tick cycle.
  task automatic test_abort_and_tie;
    applyStimulus(3'd1);
    total++; if (remaining !== 6'd20) begin bad++; $display("[TB] FAIL abort_main_rem got %0d expected 20", remaining); end
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL abort_run_done cyc=%0d got %0d expected 0", n, phase_done); end
    end
    total++; if (remaining !== 6'd19) begin bad++; $display("[TB] FAIL abort_mid_rem got %0d expected 19", remaining); end
    applyStimulus(3'd3);
    total++; if (remaining !== 6'd15) begin bad++; $display("[TB] FAIL abort_side_rem got %0d expected 15", remaining); end
    total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done got %0d expected 0", phase_done); end
    repeat (3) @(negedge clk);
    total++; if (sec_tick !== 1'b1) begin bad++; $display("[TB] FAIL tie_tick got %0d expected 1", sec_tick); end
    H = 3'b100;
    applyStimulus(3'd3);
    total++; if (remaining !== 6'd20) begin bad++; $display("[TB] FAIL tie_rem got %0d expected 20", remaining); end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      total++; if (sec_tick !== (n == 3)) begin bad++; $display("[TB] FAIL tie_tick2 cyc=%0d got %0d expected %0d", n, sec_tick, (n == 3)); end
      total++; if (remaining !== ((n < 4) ? 6'd20 : 6'd19)) begin bad++; $display("[TB] FAIL tie_rem2 cyc=%0d got %0d expected %0d", n, remaining, ((n < 4) ? 20 : 19)); end
      total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL tie_done cyc=%0d got %0d expected 0", n, phase_done); end
    end
    H = 3'b000;
  endtask

  // Illegal phase sets sticky err; async reset mid-count clears everything.
  task automatic test_err_and_async_reset;
    ped_btn = 1'b1;
    repeat (2) @(negedge clk);
    ped_btn = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(3'd7);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_set got %0d expected 1", err); end
    total++; if (remaining !== 6'd1) begin bad++; $display("[TB] FAIL err_rem got %0d expected 1", remaining); end
    applyStimulus(3'd0);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky got %0d expected 1", err); end
    total++; if (remaining !== 6'd1) begin bad++; $display("[TB] FAIL init_rem got %0d expected 1", remaining); end
    total++; if (ped_pending !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_ped got %0d expected 1", ped_pending); end
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    total++; if (remaining !== 6'd0) begin bad++; $display("[TB] FAIL areset_rem got %0d expected 0", remaining); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL areset_busy got %0d expected 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL areset_err got %0d expected 0", err); end
    total++; if (ped_pending !== 1'b0) begin bad++; $display("[TB] FAIL areset_ped got %0d expected 0", ped_pending); end
    total++; if (sec_tick !== 1'b0) begin bad++; $display("[TB] FAIL areset_tick got %0d expected 0", sec_tick); end
    total++; if (phase_done !== 1'b0) begin bad++; $display("[TB] FAIL areset_done got %0d expected 0", phase_done); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_busy got %0d expected 0", busy); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    phase      = 3'd0;
    phase_load = 1'b0;
    L          = 3'b000;
    H          = 3'b000;
    ped_btn    = 1'b0;
    test_reset;
    test_yellow;
    test_extension;
    test_ped_truncate;
    test_skip_left;
    test_abort_and_tie;
    test_err_and_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
